// File: rtl/posit_pkg.sv
// Shared helpers for the posit pack scheduler.
//   posit_nar(n)   : NaR bit pattern for an n-bit posit (sign bit only), up to 64 bits
//   POSIT_ZERO     : all-zero posit pattern, up to 64 bits
//   tag_width(n)   : bits needed to name one of n requesters (at least 1)
package posit_pkg;

  localparam logic [63:0] POSIT_ZERO = 64'd0;

  function automatic logic [63:0] posit_nar(input int unsigned n);
    return 64'd1 << (n - 1);
  endfunction

  function automatic int unsigned tag_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/packer.sv
// Combinational posit packer (positive results only).
//   seed  : signed regime value k
//   exp   : exponent field
//   frac  : fraction bits after the hidden one, MSB-aligned
//   posit : packed posit; regime saturates to maxpos/minpos, low bits truncate
module packer #(
  parameter int unsigned N  = 32,
  parameter int unsigned ES = 3
) (
  input  logic [N-1:0]  seed,
  input  logic [ES-1:0] exp,
  input  logic [N-1:0]  frac,
  output logic [N-1:0]  posit
);

  localparam int unsigned W  = ES + N + 2;
  localparam int unsigned SW = $clog2(W + 1);

  logic                neg;
  logic [N-1:0]        amt;
  logic [SW-1:0]       shamt;
  logic signed [W-1:0] pat;
  logic signed [W-1:0] shifted;
  logic [N-2:0]        body;

  // The pattern starts as the two-bit regime for k=0 ("10") or k=-1 ("01");
  // an arithmetic shift extends the leading run by |k| (k>=0) or -k-1 (k<0).
  // Shifting by W or more floods the body with the run bit, which is saturation.
  always_comb begin
    neg     = seed[N-1];
    amt     = neg ? ~seed : seed;
    shamt   = (amt > N'(W)) ? SW'(W) : amt[SW-1:0];
    pat     = {~neg, neg, exp, frac};
    shifted = pat >>> shamt;
    body    = shifted[W-1 -: N-1];
    // A run of zeros that fills the body would read as zero; clamp to minpos.
    if (body == '0) begin
      body = (N-1)'(1);
    end
    posit = {1'b0, body};
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter. Owns the priority pointer.
//   clk, rst_n : clock, synchronous active-low reset (pointer -> 0)
//   req        : request vector
//   en         : grant allowed this cycle; a grant with en high is an accept
//   gnt        : one-hot grant, zero when en is low or no request is set
//   gnt_idx    : index of the highest-priority request (valid when any request is set)
module rr_arbiter
  import posit_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  localparam int unsigned TW = tag_width(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [TW-1:0]   gnt_idx
);

  logic [TW-1:0] ptr_q, ptr_d;
  logic          found;

  // Scan from ptr upward, wrapping, and take the first set request.
  always_comb begin
    int unsigned cand;
    found   = 1'b0;
    gnt_idx = '0;
    gnt     = '0;
    cand    = 0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      cand = (32'(ptr_q) + off) % NREQ;
      if (!found && req[cand]) begin
        found   = 1'b1;
        gnt_idx = TW'(cand);
      end
    end
    if (found && en) begin
      gnt[gnt_idx] = 1'b1;
    end
    ptr_d = ptr_q;
    if (found && en) begin
      ptr_d = TW'((32'(gnt_idx) + 1) % NREQ);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/posit_pack_sched.sv
// Shares one posit packer between NREQ result producers.
//   clk, rst_n          : clock, synchronous active-low reset
//   req_valid/req_ready : per-requester handshake; req_ready is the one-hot grant
//   req_seed/exp/frac   : packer operands, slice i per requester
//   req_zero/req_nar    : special results (NaR overrides zero)
//   out_valid/out_ready : result handshake
//   out_posit/out_tag   : packed posit and originating requester index
//   busy                : any pipeline stage holds data
module posit_pack_sched
  import posit_pkg::*;
#(
  parameter int unsigned N    = 32,
  parameter int unsigned ES   = 3,
  parameter int unsigned NREQ = 4,
  localparam int unsigned TW  = tag_width(NREQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*N-1:0]  req_seed,
  input  logic [NREQ*ES-1:0] req_exp,
  input  logic [NREQ*N-1:0]  req_frac,
  input  logic [NREQ-1:0]    req_zero,
  input  logic [NREQ-1:0]    req_nar,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N-1:0]       out_posit,
  output logic [TW-1:0]      out_tag,
  output logic               busy
);

  localparam logic [N-1:0] NarVal  = N'(posit_nar(N));
  localparam logic [N-1:0] ZeroVal = N'(POSIT_ZERO);

  logic          s1_ready, s2_ready, accept, advance;
  logic [TW-1:0] gnt_idx;

  logic          s1_valid_q;
  logic [N-1:0]  s1_seed_q, s1_frac_q;
  logic [ES-1:0] s1_exp_q;
  logic          s1_zero_q, s1_nar_q;
  logic [TW-1:0] s1_tag_q;

  logic          out_valid_q;
  logic [N-1:0]  out_posit_q, out_posit_d;
  logic [TW-1:0] out_tag_q;

  logic [N-1:0]  sel_seed, sel_frac, packed_posit;
  logic [ES-1:0] sel_exp;
  logic          sel_zero, sel_nar;

  assign s2_ready = !out_valid_q || out_ready;
  assign s1_ready = !s1_valid_q || s2_ready;
  assign accept   = |req_ready;
  assign advance  = s1_valid_q && s2_ready;

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req_valid),
    .en     (s1_ready),
    .gnt    (req_ready),
    .gnt_idx(gnt_idx)
  );

  always_comb begin
    int unsigned sel;
    sel      = 32'(gnt_idx);
    sel_seed = req_seed[sel*N +: N];
    sel_exp  = req_exp[sel*ES +: ES];
    sel_frac = req_frac[sel*N +: N];
    sel_zero = req_zero[sel];
    sel_nar  = req_nar[sel];
  end

  packer #(
    .N (N),
    .ES(ES)
  ) u_packer (
    .seed (s1_seed_q),
    .exp  (s1_exp_q),
    .frac (s1_frac_q),
    .posit(packed_posit)
  );

  always_comb begin
    out_posit_d = packed_posit;
    if (s1_nar_q) begin
      out_posit_d = NarVal;
    end else if (s1_zero_q) begin
      out_posit_d = ZeroVal;
    end
  end

  // Stage 1: operand register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_seed_q  <= '0;
      s1_exp_q   <= '0;
      s1_frac_q  <= '0;
      s1_zero_q  <= 1'b0;
      s1_nar_q   <= 1'b0;
      s1_tag_q   <= '0;
    end else if (accept) begin
      s1_valid_q <= 1'b1;
      s1_seed_q  <= sel_seed;
      s1_exp_q   <= sel_exp;
      s1_frac_q  <= sel_frac;
      s1_zero_q  <= sel_zero;
      s1_nar_q   <= sel_nar;
      s1_tag_q   <= gnt_idx;
    end else if (s2_ready) begin
      s1_valid_q <= 1'b0;
    end
  end

  // Stage 2: result register; refills in the same edge it drains.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_posit_q <= '0;
      out_tag_q   <= '0;
    end else if (advance) begin
      out_valid_q <= 1'b1;
      out_posit_q <= out_posit_d;
      out_tag_q   <= s1_tag_q;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_posit = out_posit_q;
  assign out_tag   = out_tag_q;
  assign busy      = s1_valid_q || out_valid_q;

endmodule
